acti_writeback: RTL and testbench
=================================

# acti_writeback

Output-side consumer of the activation stage. Takes the one-element-per-cycle stream of activated results (data word plus finish flag) from the activation unit. Saturates each result to 16-bit Q-format and packs two results per memory word. Writes them sequentially into the output feature-map buffer starting at a per-layer base address. The final classifier layer (`layer_index == 5`) bypasses saturation and packing so that full-width logits are stored.

## Interface
Parameters:
- `DW` — 32 — width of incoming activated data and of the memory write word.
- `OW` — 16 — packed element width; `2*OW` must equal `DW`.
- `AW` — 16 — memory address width and element-count width.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — one-cycle pulse; latches config and begins a layer.
- `layer_index`  in  4  — layer number, latched at `start`; value 5 selects raw mode.
- `out_len`  in  AW  — number of elements the layer produces, latched at `start`.
- `base_addr`  in  AW  — first word address, latched at `start`.
- `acti_data`  in  DW  — signed activated result.
- `acti_valid`  in  1  — `acti_data` valid this cycle (driven by the activation finish flag).
- `mem_we`  out  1  — write strobe, registered.
- `mem_addr`  out  AW  — write address, registered.
- `mem_wdata`  out  DW  — write data, registered.
- `busy`  out  1  — high while in RUN.
- `layer_done`  out  1  — one-cycle pulse at layer completion, registered.
- `err_overrun`  out  1  — sticky; set when `acti_valid` is seen outside RUN; cleared by `start`.

## Operation
- States:
  - IDLE — `start` latches config, clears the element count, word index, half flag and `err_overrun`, then moves to RUN. If `out_len == 0`, the block instead pulses `layer_done` next cycle and stays in IDLE.
  - RUN — accepts every cycle with `acti_valid == 1`; there is no backpressure.
- Saturation (packed mode): the value is clamped to the range [-32768, 32767]. Above 32767 gives `16'h7FFF`; below -32768 gives `16'h8000`; otherwise it is `acti_data[OW-1:0]`.
- Packed mode (`layer_index != 5`):
  - Even-numbered element (half flag = 0): stores the saturated value in the hold register; no write.
  - Odd-numbered element: writes `{sat(new), hold}`, so the lower half is the earlier element.
- Raw mode (`layer_index == 5`): every element writes `acti_data` unmodified, one per word.
- Addressing: `mem_addr = base_addr + word_idx`, modulo 2^AW. `word_idx` increments after each write.
- Completion: the accepted element with `count + 1 == out_len` is the last.
  - If packed and that element is even-numbered, the block writes `{OW'h0, sat(new)}`.
  - The final write is always issued, `layer_done` pulses, and the state returns to IDLE.
- `start` during RUN is ignored.
- `acti_valid` during IDLE, including the same cycle as `start`, is dropped and sets `err_overrun`.

## Timing
- Reset values: all outputs 0, state IDLE, internal counters and hold register 0.
- Write latency: valid accepted at cycle t gives `mem_we`/`mem_addr`/`mem_wdata` at t+1. `mem_we` is high for exactly one cycle per write.
- Completion: the final element accepted at t gives the final `mem_we` and `layer_done` together at t+1, with `busy` low at t+1.
- `start` at t gives `busy` high at t+1; the first element is accepted no earlier than t+1.
- Back-to-back valids are sustained every cycle.
- Reset asserted mid-layer: immediate return to IDLE, no pending write is emitted, and `err_overrun` is cleared.
- `out_len` near 2^AW: the count compare is AW-wide; addresses wrap silently.

## Structure
- Shared package holds:
  - state encoding IDLE/RUN;
  - `RAW_LAYER = 4'd5`;
  - Q-format saturation limits `SAT_MAX`/`SAT_MIN`.
- One sub-module, `sat_clip`: combinational DW→OW signed saturation, reusable by other narrowing stages.
- The top level holds the FSM, counters, hold register and registered memory port.

## Test plan
- Packed, even length:
  - Stimulus: `start`, layer 1, `out_len=4`, `base_addr=0x100`; data 1, 2, 3, 4 on consecutive cycles.
  - Expected: writes `0x00020001`@0x100 and `0x00040003`@0x101; `layer_done` with the second write.
- Packed, odd length with saturation:
  - Stimulus: `out_len=3`; data 70000, -70000, 5.
  - Expected: `0x80007FFF`@base, then `0x00000005`@base+1 with `layer_done`.
- Raw layer:
  - Stimulus: `layer_index=5`, `out_len=2`; data -1, 0x12345678.
  - Expected: `0xFFFFFFFF`@base and `0x12345678`@base+1, unsaturated.
- Gapped valids and wrap:
  - Stimulus: `base_addr=0xFFFF`, `out_len=4`, one idle cycle between valids.
  - Expected: writes @0xFFFF then @0x0000.
- Overrun:
  - Stimulus: `acti_valid` in IDLE.
  - Expected: `err_overrun`=1, no `mem_we`; the next `start` clears it.
  - Stimulus: `start` during RUN.
  - Expected: no effect on count or address.
- Reset mid-layer:
  - Stimulus: drop `rst_n` after one packed element is held.
  - Expected: all outputs 0, no write; a new layer starts with a clean half flag.

Source files
------------

// File: rtl/acti_writeback_pkg.sv
// Shared types and constants for the activation write-back path.
package acti_writeback_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] RAW_LAYER = 4'd5;

  // Signed 16-bit Q-format limits
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

endpackage

// File: rtl/acti_writeback_if.sv
// Config, activation stream and memory write port of the write-back stage.
interface acti_writeback_if #(
  parameter int DW = 32,
  parameter int OW = 16,
  parameter int AW = 16
);
  logic          start;
  logic [3:0]    layer_index;
  logic [AW-1:0] out_len;
  logic [AW-1:0] base_addr;
  logic [DW-1:0] acti_data;
  logic          acti_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          layer_done;
  logic          err_overrun;

  modport slave (
    input  start, layer_index, out_len, base_addr, acti_data, acti_valid,
    output mem_we, mem_addr, mem_wdata, busy, layer_done, err_overrun
  );

  modport master (
    output start, layer_index, out_len, base_addr, acti_data, acti_valid,
    input  mem_we, mem_addr, mem_wdata, busy, layer_done, err_overrun
  );
endinterface

// File: rtl/acti_writeback_sat_clip.sv
// Combinational signed narrowing DW -> OW with clamping to the Q-format range.
module sat_clip
  import acti_writeback_pkg::*;
#(
  parameter int DW = 32,
  parameter int OW = 16
) (
  input  logic [DW-1:0] din_i,
  output logic [OW-1:0] dout_o
);

  localparam logic signed [DW-1:0] MAX_V = DW'(SAT_MAX);
  localparam logic signed [DW-1:0] MIN_V = DW'(SAT_MIN);

  always_comb begin
    dout_o = din_i[OW-1:0];
    if ($signed(din_i) > MAX_V) begin
      dout_o = OW'(SAT_MAX);
    end else if ($signed(din_i) < MIN_V) begin
      dout_o = OW'(SAT_MIN);
    end
  end

endmodule

// File: rtl/acti_writeback.sv
// Packs saturated activation results two per word (or raw logits for the
// classifier layer) and writes them sequentially from a per-layer base.
module acti_writeback
  import acti_writeback_pkg::*;
#(
  parameter int DW = 32,
  parameter int OW = 16,
  parameter int AW = 16
) (
  input logic              clk,
  input logic              rst_n,
  acti_writeback_if.slave  bus
);

  state_t        state_q;
  logic          raw_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] count_q;
  logic [AW-1:0] word_idx_q;
  logic          half_q;
  logic [OW-1:0] hold_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          done_q;
  logic          err_q;

  logic [OW-1:0] sat_d;
  logic [AW-1:0] count_d;
  logic [AW-1:0] addr_d;
  logic          last_d;

  sat_clip #(.DW(DW), .OW(OW)) u_sat_clip (
    .din_i  (bus.acti_data),
    .dout_o (sat_d)
  );

  assign count_d = count_q + AW'(1);
  assign last_d  = (count_d == len_q);
  assign addr_d  = base_q + word_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      raw_q       <= 1'b0;
      len_q       <= '0;
      base_q      <= '0;
      count_q     <= '0;
      word_idx_q  <= '0;
      half_q      <= 1'b0;
      hold_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            raw_q      <= (bus.layer_index == RAW_LAYER);
            len_q      <= bus.out_len;
            base_q     <= bus.base_addr;
            count_q    <= '0;
            word_idx_q <= '0;
            half_q     <= 1'b0;
            hold_q     <= '0;
            err_q      <= 1'b0;
            if (bus.out_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
          // Data arriving with no layer open is dropped; this wins over the start clear
          if (bus.acti_valid) begin
            err_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.acti_valid) begin
            count_q <= count_d;
            if (raw_q || half_q || last_d) begin
              mem_we_q   <= 1'b1;
              mem_addr_q <= addr_d;
              word_idx_q <= word_idx_q + AW'(1);
              half_q     <= 1'b0;
              if (raw_q) begin
                mem_wdata_q <= bus.acti_data;
              end else if (half_q) begin
                mem_wdata_q <= {sat_d, hold_q};
              end else begin
                mem_wdata_q <= {{OW{1'b0}}, sat_d};
              end
            end else begin
              hold_q <= sat_d;
              half_q <= 1'b1;
            end
            if (last_d) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.busy        = (state_q == S_RUN);
  assign bus.layer_done  = done_q;
  assign bus.err_overrun = err_q;

endmodule

// File: tb/tb_acti_writeback.sv
// Self-checking bench for acti_writeback: directed table, corner sequences
// and randomized layers compared against a list-based reference model.
module tb_acti_writeback;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  acti_writeback_if #(.DW(32), .OW(16), .AW(16)) bus ();

  acti_writeback #(.DW(32), .OW(16), .AW(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [15:0] got_a[$];
  logic [31:0] got_d[$];
  int          got_c[$];
  int          done_cnt = 0;
  int          done_cyc = -1;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      got_a.push_back(bus.mem_addr);
      got_d.push_back(bus.mem_wdata);
      got_c.push_back(cyc);
    end
    if (bus.layer_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  logic [31:0] stim_q[$];
  logic [15:0] exp_a[$];
  logic [31:0] exp_d[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [31:0] v);
    int s;
    s = v;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  // Reference: list of results -> list of memory words, straight from the layer rules
  task automatic build_expect(input logic [3:0] layer, input logic [15:0] base);
    int n;
    logic [15:0] a;
    logic [15:0] hi;
    n = stim_q.size();
    exp_a.delete();
    exp_d.delete();
    a = base;
    if (layer == 4'd5) begin
      for (int k = 0; k < n; k++) begin
        exp_a.push_back(a);
        exp_d.push_back(stim_q[k]);
        a = a + 16'd1;
      end
    end else begin
      for (int k = 0; 2 * k < n; k++) begin
        hi = (2 * k + 1 < n) ? sat16(stim_q[2 * k + 1]) : 16'h0000;
        exp_a.push_back(a);
        exp_d.push_back({hi, sat16(stim_q[2 * k])});
        a = a + 16'd1;
      end
    end
  endtask

  task automatic run_layer(input string name, input logic [3:0] layer, input logic [15:0] len,
                           input logic [15:0] base, input int gap, input int restart_at,
                           input bit v_at_start);
    int last_cyc;
    int w0;
    int d0;
    int nw;
    w0 = got_a.size();
    d0 = done_cnt;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.layer_index = layer;
    bus.out_len     = len;
    bus.base_addr   = base;
    if (v_at_start) begin
      bus.acti_valid = 1'b1;
      bus.acti_data  = 32'h0BAD_0BAD;
    end
    last_cyc = cyc;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.acti_valid = 1'b0;
    chk({name, "_busy_after_start"}, 64'(bus.busy), 64'(len != 16'd0));
    for (int i = 0; i < stim_q.size(); i++) begin
      bus.acti_valid = 1'b1;
      bus.acti_data  = stim_q[i];
      if (i == restart_at) begin
        bus.start       = 1'b1;
        bus.base_addr   = 16'h0999;
        bus.out_len     = 16'd2;
        bus.layer_index = 4'd5;
      end
      last_cyc = cyc;
      @(negedge clk);
      bus.acti_valid = 1'b0;
      bus.start      = 1'b0;
      repeat (gap) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    nw = got_a.size() - w0;
    chk({name, "_nwrites"}, 64'(nw), 64'(exp_a.size()));
    for (int k = 0; k < exp_a.size() && k < nw; k++) begin
      chk($sformatf("%s_addr%0d", name, k), 64'(got_a[w0 + k]), 64'(exp_a[k]));
      chk($sformatf("%s_data%0d", name, k), 64'(got_d[w0 + k]), 64'(exp_d[k]));
    end
    chk({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    chk({name, "_done_latency"}, 64'(done_cyc), 64'(last_cyc + 1));
    if (nw > 0) chk({name, "_last_wr_latency"}, 64'(got_c[got_c.size() - 1]), 64'(last_cyc + 1));
    chk({name, "_busy_after_end"}, 64'(bus.busy), 64'd0);
  endtask

  typedef struct packed {
    logic [3:0]        layer;
    logic [15:0]       len;
    logic [15:0]       base;
    logic [1:0]        gap;
    logic [3:0][31:0]  d;
    logic [1:0]        nw;
    logic [1:0][15:0]  ea;
    logic [1:0][31:0]  ed;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] layer, input logic [15:0] len, input logic [15:0] base,
                              input logic [1:0] gap, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3, input logic [1:0] nw,
                              input logic [15:0] a0, input logic [31:0] w0,
                              input logic [15:0] a1, input logic [31:0] w1);
    vec_t v;
    v.layer = layer; v.len = len; v.base = base; v.gap = gap;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.nw = nw; v.ea[0] = a0; v.ed[0] = w0; v.ea[1] = a1; v.ed[1] = w1;
    return v;
  endfunction

  vec_t tbl[6];
  logic [3:0]  r_layer;
  logic [15:0] r_len;
  logic [15:0] r_base;
  logic [31:0] r_v;

  initial begin
    bus.start = 1'b0; bus.layer_index = '0; bus.out_len = '0; bus.base_addr = '0;
    bus.acti_data = '0; bus.acti_valid = 1'b0;

    tbl[0] = mk(4'd1, 16'd4, 16'h0100, 2'd0, 32'd1, 32'd2, 32'd3, 32'd4,
                2'd2, 16'h0100, 32'h0002_0001, 16'h0101, 32'h0004_0003);
    tbl[1] = mk(4'd2, 16'd3, 16'h0200, 2'd0, 32'd70000, -32'sd70000, 32'd5, 32'd0,
                2'd2, 16'h0200, 32'h8000_7FFF, 16'h0201, 32'h0000_0005);
    tbl[2] = mk(4'd5, 16'd2, 16'h0300, 2'd0, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0, 32'd0,
                2'd2, 16'h0300, 32'hFFFF_FFFF, 16'h0301, 32'h1234_5678);
    tbl[3] = mk(4'd0, 16'd4, 16'hFFFF, 2'd1, 32'd1, 32'd2, 32'd3, 32'd4,
                2'd2, 16'hFFFF, 32'h0002_0001, 16'h0000, 32'h0004_0003);
    tbl[4] = mk(4'd3, 16'd1, 16'h0010, 2'd0, 32'd32767, 32'd0, 32'd0, 32'd0,
                2'd1, 16'h0010, 32'h0000_7FFF, 16'h0000, 32'h0);
    tbl[5] = mk(4'd6, 16'd2, 16'h0020, 2'd2, 32'hFFFF_8000, 32'd32768, 32'd0, 32'd0,
                2'd1, 16'h0020, 32'h7FFF_8000, 16'h0000, 32'h0);

    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.layer_done, bus.err_overrun}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      stim_q.delete(); exp_a.delete(); exp_d.delete();
      for (int j = 0; j < int'(tbl[i].len); j++) stim_q.push_back(tbl[i].d[j]);
      for (int k = 0; k < int'(tbl[i].nw); k++) begin
        exp_a.push_back(tbl[i].ea[k]);
        exp_d.push_back(tbl[i].ed[k]);
      end
      run_layer($sformatf("vec%0d", i), tbl[i].layer, tbl[i].len, tbl[i].base, int'(tbl[i].gap), -1, 1'b0);
    end

    // Overrun in IDLE: sticky flag, nothing written; next start clears it
    begin
      int w0;
      w0 = got_a.size();
      @(negedge clk);
      bus.acti_valid = 1'b1; bus.acti_data = 32'h5555_5555;
      @(negedge clk);
      bus.acti_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("overrun_set", 64'(bus.err_overrun), 64'd1);
      chk("overrun_no_write", 64'(got_a.size() - w0), 64'd0);
    end
    stim_q = '{32'd9, 32'd8};
    build_expect(4'd1, 16'h0400);
    run_layer("after_overrun", 4'd1, 16'd2, 16'h0400, 0, -1, 1'b0);
    chk("overrun_cleared", 64'(bus.err_overrun), 64'd0);

    // Valid in the same cycle as start is dropped and flagged
    stim_q = '{32'd1, 32'd2};
    build_expect(4'd1, 16'h0410);
    run_layer("valid_at_start", 4'd1, 16'd2, 16'h0410, 0, -1, 1'b1);
    chk("valid_at_start_err", 64'(bus.err_overrun), 64'd1);

    // Start during RUN is ignored
    stim_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    build_expect(4'd1, 16'h0040);
    run_layer("start_in_run", 4'd1, 16'd4, 16'h0040, 0, 1, 1'b0);

    // Reset mid-layer with one element held and the overrun flag set
    begin
      int w0;
      w0 = got_a.size();
      @(negedge clk);
      bus.start = 1'b1; bus.layer_index = 4'd1; bus.out_len = 16'd4; bus.base_addr = 16'h0500;
      bus.acti_valid = 1'b1; bus.acti_data = 32'd99;
      @(negedge clk);
      bus.start = 1'b0;
      bus.acti_data = 32'd7;
      @(negedge clk);
      bus.acti_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.layer_done, bus.err_overrun}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("midreset_no_write", 64'(got_a.size() - w0), 64'd0);
    end
    stim_q = '{32'd1, 32'd2};
    build_expect(4'd1, 16'h0600);
    run_layer("after_reset", 4'd1, 16'd2, 16'h0600, 0, -1, 1'b0);

    for (int r = 0; r < 25; r++) begin
      r_layer = 4'($urandom_range(0, 6));
      r_len   = 16'($urandom_range(0, 9));
      r_base  = 16'($urandom);
      stim_q.delete();
      for (int i = 0; i < int'(r_len); i++) begin
        case ($urandom_range(0, 2))
          0: r_v = $urandom;
          1: r_v = 32'(int'($urandom_range(0, 131071)) - 65536);
          default: r_v = 32'($urandom_range(0, 255));
        endcase
        stim_q.push_back(r_v);
      end
      build_expect(r_layer, r_base);
      run_layer($sformatf("rnd%0d", r), r_layer, r_len, r_base, int'($urandom_range(0, 2)), -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
